// File: rtl/me_stage_pkg.sv
// rtl/me_stage_pkg.sv - shared load-op codes, bus widths and bus bit offsets for the EX/ME/WB stages
package me_stage_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  localparam int EX_ME_W = 74;
  localparam int ME_WB_W = 70;
  localparam int FWD_W   = 37;

  // EX->ME bus: {pc, alu_result, ld_op, res_from_mem, gr_we, dest}
  localparam int EX_DEST_LSB  = 0;
  localparam int EX_GR_WE     = 5;
  localparam int EX_RES_MEM   = 6;
  localparam int EX_LD_OP_LSB = 7;
  localparam int EX_ALU_LSB   = 10;
  localparam int EX_PC_LSB    = 42;

  // ME->WB bus: {pc, final_result, gr_we, dest}
  localparam int WB_DEST_LSB  = 0;
  localparam int WB_GR_WE     = 5;
  localparam int WB_RES_LSB   = 6;
  localparam int WB_PC_LSB    = 38;

endpackage

// File: rtl/me_stage_load_align.sv
// rtl/me_stage_load_align.sv - byte/half extraction and sign/zero extension of load data
// Only present when ME_SUBWORD_LOAD_EN is defined.
`ifdef ME_SUBWORD_LOAD_EN
module me_stage_load_align
  import me_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_op,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // addr[0] is ignored for halves; misalignment is trapped upstream
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op)
      LD_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ext_data = {24'd0, byte_sel};
      LD_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   ext_data = {16'd0, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule
`endif

// File: rtl/me_stage.sv
// rtl/me_stage.sv - memory-access pipeline stage with one-entry load-data hold buffer
// ME_SUBWORD_LOAD_EN enables byte/half load alignment; otherwise loads return the raw word.
module me_stage #(
  parameter int DATA_W  = 32,
  parameter int EX_ME_W = 74,
  parameter int ME_WB_W = 70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               EX_to_ME_Valid,
  input  logic [EX_ME_W-1:0] EX_to_ME_Bus,
  output logic               ME_Allow_in,
  input  logic               WB_Allow_in,
  output logic               ME_to_WB_Valid,
  output logic [ME_WB_W-1:0] ME_to_WB_Bus,
  input  logic [DATA_W-1:0]  data_sram_rdata,
  output logic [4:0]         ME_dest,
  output logic [DATA_W+4:0]  ME_Forward
);

  import me_stage_pkg::*;

  logic              me_valid;
  logic              fresh;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] alu_q;
  logic [2:0]        ld_op_q;
  logic              res_mem_q;
  logic              gr_we_q;
  logic [4:0]        dest_q;

  logic              ready_go;
  logic [DATA_W-1:0] raw_rdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;

  assign ready_go       = 1'b1;
  assign ME_Allow_in    = !me_valid | (ready_go & WB_Allow_in);
  assign ME_to_WB_Valid = me_valid & ready_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      me_valid  <= 1'b0;
      fresh     <= 1'b0;
      buf_valid <= 1'b0;
      buf_data  <= '0;
      pc_q      <= '0;
      alu_q     <= '0;
      ld_op_q   <= '0;
      res_mem_q <= 1'b0;
      gr_we_q   <= 1'b0;
      dest_q    <= '0;
    end else if (ME_Allow_in) begin
      me_valid  <= EX_to_ME_Valid;
      fresh     <= EX_to_ME_Valid;
      buf_valid <= 1'b0;
      if (EX_to_ME_Valid) begin
        pc_q      <= EX_to_ME_Bus[EX_PC_LSB +: DATA_W];
        alu_q     <= EX_to_ME_Bus[EX_ALU_LSB +: DATA_W];
        ld_op_q   <= EX_to_ME_Bus[EX_LD_OP_LSB +: 3];
        res_mem_q <= EX_to_ME_Bus[EX_RES_MEM];
        gr_we_q   <= EX_to_ME_Bus[EX_GR_WE];
        dest_q    <= EX_to_ME_Bus[EX_DEST_LSB +: 5];
      end
    end else begin
      fresh <= 1'b0;
      // SRAM data is only valid in the fresh cycle; keep it while WB stalls
      if (fresh & me_valid & !WB_Allow_in) begin
        buf_data  <= data_sram_rdata;
        buf_valid <= 1'b1;
      end
    end
  end

  assign raw_rdata = fresh ? data_sram_rdata : (buf_valid ? buf_data : '0);

`ifdef ME_SUBWORD_LOAD_EN
  me_stage_load_align u_load_align (
    .rdata    (raw_rdata),
    .addr     (alu_q[1:0]),
    .ld_op    (ld_op_q),
    .ext_data (load_data)
  );
`else
  logic unused_ld_op;
  assign unused_ld_op = ^ld_op_q;
  assign load_data    = raw_rdata;
`endif

  assign final_result = res_mem_q ? load_data : alu_q;
  assign ME_dest      = me_valid ? dest_q : 5'd0;
  assign ME_Forward   = {ME_dest, final_result};
  assign ME_to_WB_Bus = {pc_q, final_result, gr_we_q, dest_q};

endmodule

// File: tb/tb_me_stage.sv
// tb/tb_me_stage.sv - scoreboard bench for me_stage (expectations follow ME_SUBWORD_LOAD_EN)
module tb_me_stage;
  import me_stage_pkg::*;

`ifdef ME_SUBWORD_LOAD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  // {ld_op, addr, rdata, aligned result}
  localparam logic [68:0] SW_TAB [9] = '{
    {LD_B,  2'd3, 32'h80FF_0011, 32'hFFFF_FF80},
    {LD_BU, 2'd3, 32'h80FF_0011, 32'h0000_0080},
    {LD_H,  2'd2, 32'h8001_7FFF, 32'hFFFF_8001},
    {LD_HU, 2'd2, 32'h8001_7FFF, 32'h0000_8001},
    {LD_H,  2'd3, 32'h8001_7FFF, 32'hFFFF_8001},
    {LD_B,  2'd0, 32'h80FF_0011, 32'h0000_0011},
    {LD_BU, 2'd2, 32'h80FF_0011, 32'h0000_00FF},
    {LD_H,  2'd0, 32'h8001_7FFF, 32'h0000_7FFF},
    {3'd7,  2'd1, 32'h80FF_0011, 32'h80FF_0011}
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [73:0] ex_bus;
  logic        me_allow;
  logic        wb_allow;
  logic        wb_valid;
  logic [69:0] wb_bus;
  logic [31:0] rdata;
  logic [4:0]  me_dest;
  logic [36:0] me_forward;

  int tests = 0;
  int fails = 0;
  logic [69:0] sb[$];

  always #5 clk = ~clk;

  me_stage dut (
    .clk             (clk),
    .reset           (reset),
    .EX_to_ME_Valid  (ex_valid),
    .EX_to_ME_Bus    (ex_bus),
    .ME_Allow_in     (me_allow),
    .WB_Allow_in     (wb_allow),
    .ME_to_WB_Valid  (wb_valid),
    .ME_to_WB_Bus    (wb_bus),
    .data_sram_rdata (rdata),
    .ME_dest         (me_dest),
    .ME_Forward      (me_forward)
  );

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [2:0] op, input logic rm, input logic [4:0] d);
    ex_valid = v;
    ex_bus   = {pc, alu, op, rm, 1'b1, d};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive_ex(1'b0, 32'h0, 32'h0, LD_W, 1'b0, 5'd0);
    wb_allow = 1'b1;
    rdata = 32'h0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
    tests++; if (me_allow !== 1'b1) begin fails++; $display("FAIL reset_allow: got %b expected 1", me_allow); end
    tests++; if (me_dest !== 5'd0) begin fails++; $display("FAIL reset_dest: got %h expected 0", me_dest); end
    tests++; if (me_forward !== 37'd0) begin fails++; $display("FAIL reset_forward: got %h expected 0", me_forward); end
    tests++; if (wb_bus !== 70'd0) begin fails++; $display("FAIL reset_bus: got %h expected 0", wb_bus); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_alu_passthrough;
    logic [69:0] exp;
    @(posedge clk); #1;
    drive_ex(1'b1, 32'h0000_1000, 32'h1234_5678, LD_W, 1'b0, 5'd5);
    sb.push_back({32'h0000_1000, 32'h1234_5678, 1'b1, 5'd5});
    @(posedge clk); #1;
    drive_ex(1'b0, 32'h0, 32'h0, LD_W, 1'b0, 5'd0);
    @(negedge clk);
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL passthru_valid: got %b expected 1", wb_valid); end
    tests++; if (me_forward !== {5'd5, 32'h1234_5678}) begin fails++; $display("FAIL passthru_forward: got %h expected %h", me_forward, {5'd5, 32'h1234_5678}); end
    tests++;
    if (sb.size() == 0) begin fails++; $display("FAIL passthru_sb: output with empty scoreboard"); end
    else begin
      exp = sb.pop_front();
      if (wb_bus !== exp) begin fails++; $display("FAIL passthru_bus: got %h expected %h", wb_bus, exp); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b expected 0", wb_valid); end
    tests++; if (me_dest !== 5'd0) begin fails++; $display("FAIL idle_dest: got %h expected 0", me_dest); end
  endtask

  task automatic test_subword_load;
    logic [68:0] ent;
    logic [31:0] expv;
    logic [31:0] pc;
    logic [4:0]  d;
    logic [69:0] exp;
    for (int i = 0; i < 9; i++) begin
      ent  = SW_TAB[i];
      expv = SUBWORD ? ent[31:0] : ent[63:32];
      pc   = 32'h0000_2000 + 32'(i * 4);
      d    = 5'(6 + i);
      @(posedge clk); #1;
      drive_ex(1'b1, pc, {30'h40, ent[65:64]}, ent[68:66], 1'b1, d);
      rdata = 32'h5555_5555;
      sb.push_back({pc, expv, 1'b1, d});
      @(posedge clk); #1;
      drive_ex(1'b0, 32'h0, 32'h0, LD_W, 1'b0, 5'd0);
      rdata = ent[63:32];
      @(negedge clk);
      tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL load%0d_valid: got %b expected 1", i, wb_valid); end
      tests++; if (me_forward !== {d, expv}) begin fails++; $display("FAIL load%0d_forward: got %h expected %h", i, me_forward, {d, expv}); end
      tests++;
      if (sb.size() == 0) begin fails++; $display("FAIL load%0d_sb: output with empty scoreboard", i); end
      else begin
        exp = sb.pop_front();
        if (wb_bus !== exp) begin fails++; $display("FAIL load%0d_bus: got %h expected %h", i, wb_bus, exp); end
      end
    end
  endtask

  task automatic test_stall;
    logic [69:0] exp;
    @(posedge clk); #1;
    drive_ex(1'b1, 32'h0000_3000, 32'h0000_0400, LD_W, 1'b1, 5'd3);
    sb.push_back({32'h0000_3000, 32'hDEAD_BEEF, 1'b1, 5'd3});
    @(posedge clk); #1;
    drive_ex(1'b1, 32'h0000_3004, 32'hA5A5_A5A5, LD_W, 1'b0, 5'd7);
    sb.push_back({32'h0000_3004, 32'hA5A5_A5A5, 1'b1, 5'd7});
    rdata = 32'hDEAD_BEEF;
    wb_allow = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        rdata = 32'h0;
      end
      @(negedge clk);
      tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL stall%0d_valid: got %b expected 1", c, wb_valid); end
      tests++; if (me_allow !== 1'b0) begin fails++; $display("FAIL stall%0d_allow: got %b expected 0", c, me_allow); end
      tests++; if (wb_bus[37:6] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stall%0d_result: got %h expected deadbeef", c, wb_bus[37:6]); end
    end
    @(posedge clk); #1;
    wb_allow = 1'b1;
    @(negedge clk);
    tests++;
    if (sb.size() == 0) begin fails++; $display("FAIL stall_release_sb: output with empty scoreboard"); end
    else begin
      exp = sb.pop_front();
      if (wb_bus !== exp) begin fails++; $display("FAIL stall_release_bus: got %h expected %h", wb_bus, exp); end
    end
    @(posedge clk); #1;
    drive_ex(1'b0, 32'h0, 32'h0, LD_W, 1'b0, 5'd0);
    @(negedge clk);
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL stall_next_valid: got %b expected 1", wb_valid); end
    tests++;
    if (sb.size() == 0) begin fails++; $display("FAIL stall_next_sb: output with empty scoreboard"); end
    else begin
      exp = sb.pop_front();
      if (wb_bus !== exp) begin fails++; $display("FAIL stall_next_bus: got %h expected %h", wb_bus, exp); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL stall_once: got %b expected 0", wb_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd [5];
    logic [31:0] alu;
    logic [31:0] pc;
    logic [69:0] exp;
    for (int i = 0; i < 5; i++) rd[i] = $urandom;
    wb_allow = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      rdata = rd[s];
      if (s < 4) begin
        pc = 32'h0000_4000 + 32'(s * 4);
        if (s % 2 == 1) begin
          alu = 32'h0000_0300 + 32'(s * 4);
          drive_ex(1'b1, pc, alu, LD_W, 1'b1, 5'(10 + s));
          sb.push_back({pc, rd[s + 1], 1'b1, 5'(10 + s)});
        end else begin
          alu = $urandom;
          drive_ex(1'b1, pc, alu, 3'($urandom_range(0, 7)), 1'b0, 5'(10 + s));
          sb.push_back({pc, alu, 1'b1, 5'(10 + s)});
        end
      end else begin
        drive_ex(1'b0, 32'h0, 32'h0, LD_W, 1'b0, 5'd0);
      end
      @(negedge clk);
      if (s > 0) begin
        tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL b2b%0d_valid: got %b expected 1", s, wb_valid); end
        tests++; if (me_allow !== 1'b1) begin fails++; $display("FAIL b2b%0d_allow: got %b expected 1", s, me_allow); end
        tests++;
        if (sb.size() == 0) begin fails++; $display("FAIL b2b%0d_sb: output with empty scoreboard", s); end
        else begin
          exp = sb.pop_front();
          if (wb_bus !== exp) begin fails++; $display("FAIL b2b%0d_bus: got %h expected %h", s, wb_bus, exp); end
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle_valid: got %b expected 0", wb_valid); end
    tests++; if (me_dest !== 5'd0) begin fails++; $display("FAIL b2b_idle_dest: got %h expected 0", me_dest); end
  endtask

  task automatic test_async_reset;
    logic [69:0] exp;
    @(posedge clk); #1;
    drive_ex(1'b1, 32'h0000_5000, 32'h0000_0500, LD_W, 1'b1, 5'd9);
    wb_allow = 1'b1;
    @(posedge clk); #1;
    drive_ex(1'b0, 32'h0, 32'h0, LD_W, 1'b0, 5'd0);
    rdata = 32'hCAFE_F00D;
    wb_allow = 1'b0;
    @(posedge clk); #1;
    rdata = 32'h0;
    @(negedge clk);
    tests++; if (me_allow !== 1'b0) begin fails++; $display("FAIL areset_pre_allow: got %b expected 0", me_allow); end
    #1 reset = 1'b0;
    #1;
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b expected 0", wb_valid); end
    tests++; if (me_allow !== 1'b1) begin fails++; $display("FAIL areset_allow: got %b expected 1", me_allow); end
    tests++; if (me_forward !== 37'd0) begin fails++; $display("FAIL areset_forward: got %h expected 0", me_forward); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    drive_ex(1'b1, 32'h0000_6000, 32'h0000_0600, LD_W, 1'b1, 5'd4);
    sb.push_back({32'h0000_6000, 32'h1122_3344, 1'b1, 5'd4});
    @(posedge clk); #1;
    drive_ex(1'b0, 32'h0, 32'h0, LD_W, 1'b0, 5'd0);
    rdata = 32'h1122_3344;
    @(negedge clk);
    tests++; if (wb_bus[37:6] !== 32'h1122_3344) begin fails++; $display("FAIL post_reset_fresh: got %h expected 11223344", wb_bus[37:6]); end
    @(posedge clk); #1;
    rdata = 32'h0;
    @(negedge clk);
    tests++; if (wb_bus[37:6] !== 32'h1122_3344) begin fails++; $display("FAIL post_reset_held: got %h expected 11223344", wb_bus[37:6]); end
    @(posedge clk); #1;
    wb_allow = 1'b1;
    @(negedge clk);
    tests++;
    if (sb.size() == 0) begin fails++; $display("FAIL post_reset_sb: output with empty scoreboard"); end
    else begin
      exp = sb.pop_front();
      if (wb_bus !== exp) begin fails++; $display("FAIL post_reset_bus: got %h expected %h", wb_bus, exp); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_subword_load();
    test_stall();
    test_back_to_back();
    test_async_reset();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: %0d entries left expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
